// File: rtl/i2c_als_target.sv
// rtl/i2c_als_target.sv - I2C target presenting ambient-light-sensor data over a byte register map
`timescale 1ns/1ps
module i2c_als_target #(
  parameter logic [6:0] ALS_ADDR  = 7'h39,
  parameter logic [7:0] DEVICE_ID = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  input  logic [15:0] cct_in,
  input  logic [15:0] lux_in,
  input  logic        data_ready,
  output logic [7:0]  ctrl_out,
  output logic        busy,
  output logic        rd_done
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_PTR       = 4'd3;
  localparam logic [3:0] S_PTR_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RACK      = 4'd8;

  logic [3:0]  state;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_d, sda_d;
  logic [2:0]  bitcnt;
  logic [7:0]  sh;
  logic [3:0]  ptr;
  logic        phase;
  logic        sda_oe;
  logic [15:0] sh_cct, sh_lux;
  logic        sh_rdy;
  logic [7:0]  rd_byte;

  logic scl_q, sda_q, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  assign i2c_sda   = sda_oe ? 1'b0 : 1'bz;
  assign scl_q     = scl_sync[1];
  assign sda_q     = sda_sync[1];
  assign scl_rise  = scl_q & ~scl_d;
  assign scl_fall  = ~scl_q & scl_d;
  assign start_det = scl_q & scl_d & sda_d & ~sda_q;
  assign stop_det  = scl_q & scl_d & ~sda_d & sda_q;
  assign rx_byte   = {sh[6:0], sda_q};

  // Read data comes only from the shadow copy so multi-byte reads stay coherent.
  always_comb begin
    rd_byte = 8'h00;
    case (ptr)
      4'h0:    rd_byte = sh_cct[7:0];
      4'h1:    rd_byte = sh_cct[15:8];
      4'h2:    rd_byte = sh_lux[7:0];
      4'h3:    rd_byte = sh_lux[15:8];
      4'h4:    rd_byte = ctrl_out;
      4'h5:    rd_byte = {7'b0, sh_rdy};
      4'hF:    rd_byte = DEVICE_ID;
      default: rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      bitcnt   <= 3'd0;
      sh       <= 8'h00;
      ptr      <= 4'h0;
      phase    <= 1'b0;
      sda_oe   <= 1'b0;
      sh_cct   <= 16'h0000;
      sh_lux   <= 16'h0000;
      sh_rdy   <= 1'b0;
      ctrl_out <= 8'h00;
      busy     <= 1'b0;
      rd_done  <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[0], i2c_scl};
      sda_sync <= {sda_sync[0], i2c_sda};
      scl_d    <= scl_q;
      sda_d    <= sda_q;
      rd_done  <= 1'b0;
      if (start_det) begin
        state  <= S_ADDR;
        bitcnt <= 3'd0;
        phase  <= 1'b0;
        sda_oe <= 1'b0;
      end else if (stop_det) begin
        state  <= S_IDLE;
        phase  <= 1'b0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise) begin
              sh     <= rx_byte;
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                case (state)
                  S_ADDR: begin
                    busy  <= (rx_byte[7:1] == ALS_ADDR);
                    state <= (rx_byte[7:1] == ALS_ADDR) ? S_ADDR_ACK : S_IDLE;
                  end
                  S_PTR: begin
                    ptr   <= rx_byte[3:0];
                    state <= S_PTR_ACK;
                  end
                  default: begin
                    if (ptr == 4'h4) ctrl_out <= rx_byte;
                    ptr   <= ptr + 4'd1;
                    state <= S_WDATA_ACK;
                  end
                endcase
              end
            end
          end
          // phase=0: SCL fall that opens the ACK bit; phase=1: SCL fall that closes it.
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                phase  <= 1'b1;
                sda_oe <= 1'b1;
                if (state == S_ADDR_ACK && sh[0]) begin
                  sh_cct <= cct_in;
                  sh_lux <= lux_in;
                  sh_rdy <= data_ready;
                end
              end else begin
                phase  <= 1'b0;
                bitcnt <= 3'd0;
                sda_oe <= 1'b0;
                if (state == S_ADDR_ACK && sh[0]) begin
                  sh     <= rd_byte;
                  sda_oe <= ~rd_byte[7];
                  state  <= S_RDATA;
                end else if (state == S_ADDR_ACK) begin
                  state <= S_PTR;
                end else begin
                  state <= S_WDATA;
                end
              end
            end
          end
          S_RDATA: begin
            if (scl_fall) begin
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                sda_oe <= 1'b0;
                state  <= S_RACK;
              end else begin
                sh     <= {sh[6:0], 1'b0};
                sda_oe <= ~sh[6];
              end
            end
          end
          S_RACK: begin
            if (scl_rise && !phase) begin
              if (!sda_q) begin
                phase   <= 1'b1;
                ptr     <= ptr + 4'd1;
                rd_done <= 1'b1;
              end else begin
                state <= S_IDLE;
              end
            end else if (scl_fall && phase) begin
              phase  <= 1'b0;
              bitcnt <= 3'd0;
              sh     <= rd_byte;
              sda_oe <= ~rd_byte[7];
              state  <= S_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
